// File: rtl/if_stage_pipe.sv
// if_stage_pipe -- instruction-fetch stage plus IF/ID pipeline register.
//
// Owns the PC, drives the instruction-memory address, and latches the fetched
// word together with PC+4 for the ID stage. ID feeds back its hazard stalls and
// redirect requests (J/JAL, JR, taken branch). The fetch stage uses these to
// hold the PC, redirect it, or squash the IF/ID contents.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_addr         fetch address (always equal to the PC register)
//   imem_rdata/ready  fetched word, valid in the same cycle when ready=1
//   stall, stall_beq  load-use / branch-operand hazard holds from ID
//   branch_enable     ID redirect request
//   is_jump_index, jump_index  J/JAL target field
//   is_jr, jr_target           JR target (forwarded rs)
//   branch_imm        branch offset field of the ID instruction
//   id_instruction, id_pc_4, id_valid  IF/ID register outputs
//   jr_misalign       one-cycle pulse for an accepted JR with target[1:0]!=0
//
// Optional build macro IF_DELAY_SLOT_EN:
//   defined   -> MIPS delay slot (the word at the current PC survives a redirect)
//   undefined -> a redirect flushes IF/ID (1 bubble of penalty)
module if_stage_pipe #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        stall_beq,
  input  logic        branch_enable,
  input  logic        is_jump_index,
  input  logic [25:0] jump_index,
  input  logic        is_jr,
  input  logic [31:0] jr_target,
  input  logic [15:0] branch_imm,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc_4,
  output logic        id_valid,
  output logic        jr_misalign
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;

  logic        hold, redirect;
  logic [31:0] pc_plus4, br_off, target;

  assign hold     = stall | stall_beq;
  // ID's branch compare is stale while it is holding, so the redirect waits.
  assign redirect = branch_enable & ~hold;
  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  // JR wins over J/JAL, which wins over a conditional branch.
  always_comb begin
    target = pc4_q + br_off;
    if (is_jr)              target = {jr_target[31:2], 2'b00};
    else if (is_jump_index) target = {pc4_q[31:28], jump_index, 2'b00};
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    mis_d   = redirect & is_jr & (jr_target[1:0] != 2'b00);
    if (hold) begin
      // freeze everything; memory data is ignored
    end else if (redirect) begin
      pc_d  = target;
      pc4_d = pc_plus4;
`ifdef IF_DELAY_SLOT_EN
      // Keep the delay-slot word if memory delivered it; otherwise the slot is
      // lost but the redirect still takes effect.
      if (imem_ready) begin
        instr_d = imem_rdata;
        valid_d = 1'b1;
      end else begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
`else
      instr_d = NOP_WORD;
      valid_d = 1'b0;
`endif
    end else if (!imem_ready) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      instr_d = imem_rdata;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign imem_addr      = pc_q;
  assign id_instruction = instr_q;
  assign id_pc_4        = pc4_q;
  assign id_valid       = valid_q;
  assign jr_misalign    = mis_q;

endmodule

// File: doc/if_stage_pipe.md
Name: if_stage_pipe

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Sits directly upstream of the ID-stage control unit.
- Owns the PC, issues instruction-memory addresses, and latches the fetched instruction and PC+4 for ID.
- Consumes ID's redirect and stall decisions (jump, JR, taken branch, load-use stall, branch-operand stall) to hold, redirect or squash fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word injected into IF/ID on bubble or flush.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- imem_addr  output  32  fetch address; equals the PC register.
- imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle when imem_ready=1.
- imem_ready  input  1  memory has valid data this cycle.
- stall  input  1  load-use hazard stall from ID.
- stall_beq  input  1  branch-operand hazard stall from ID.
- branch_enable  input  1  ID requests redirect (jump, JR or taken branch).
- is_jump_index  input  1  J/JAL in ID.
- jump_index  input  26  J/JAL index field.
- is_jr  input  1  JR in ID.
- jr_target  input  32  forwarded rs value for JR.
- branch_imm  input  16  ID instruction[15:0], used for the branch offset.
- id_instruction  output  32  IF/ID instruction register.
- id_pc_4  output  32  IF/ID PC+4 register.
- id_valid  output  1  IF/ID holds a real fetched instruction (0 = bubble).
- jr_misalign  output  1  one-cycle registered pulse: an accepted JR target had bits [1:0] != 0.

Behaviour:
- Reset values, applied on the edge where rst=1 and overriding all other inputs:
  - pc = RESET_PC
  - id_instruction = NOP_WORD
  - id_pc_4 = 0
  - id_valid = 0
  - jr_misalign = 0
- hold = stall | stall_beq.
- redirect = branch_enable & ~hold. Redirect is ignored while hold=1, because ID's branch compare is stale.
- Target selection, priority is_jr > is_jump_index > branch:
  - JR target: {jr_target[31:2], 2'b00}.
  - Jump target: {id_pc_4[31:28], jump_index, 2'b00}.
  - Branch target: id_pc_4 + {{14{branch_imm[15]}}, branch_imm, 2'b00}. Use 32-bit modulo addition; wrap-around is allowed and not flagged.
- Per-cycle update, priority order top to bottom:
  1. rst: reset values as listed above.
  2. hold=1: pc, id_instruction, id_pc_4 and id_valid all keep their values. imem_ready is ignored.
  3. redirect=1:
     - pc <= target.
     - IF/ID is flushed: id_instruction <= NOP_WORD, id_valid <= 0, id_pc_4 <= pc+4.
     - This applies regardless of imem_ready.
     - Delay-slot variant: see Optional Feature.
  4. imem_ready=0: pc holds; IF/ID loads a bubble (NOP_WORD, id_valid=0); id_pc_4 holds.
  5. Otherwise: pc <= pc+4; id_instruction <= imem_rdata; id_pc_4 <= pc+4; id_valid <= 1.
- jr_misalign <= redirect & is_jr & (jr_target[1:0] != 0). Otherwise 0.
- pc[1:0] is always 00. PC+4 wraps from 32'hFFFF_FFFC to 0.
- Latency: an instruction at address A, with imem_ready=1 and no hold, appears on id_instruction one cycle after pc=A.
- Redirect penalty: 1 bubble without the delay slot, 0 with it.

Optional Feature:
- Macro IF_DELAY_SLOT_EN.
- Defined: MIPS branch delay slot.
  - On redirect with imem_ready=1, the word at the current pc is latched into IF/ID: id_valid=1, id_pc_4=pc+4.
  - pc <= target.
  - If imem_ready=0 on a redirect, a bubble is latched and pc <= target. The slot is lost; a redirect request in ID is never dropped.
- Undefined: flush behaviour exactly as in item 3 of Behaviour.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: rst high for 2 cycles, then imem_ready=1 with words W0..W3 from address 0.
  - Required: id_valid=0 during reset; then id_instruction=W0 with id_pc_4=4, W1 with 8, and so on. pc advances 0, 4, 8, 12.
- Load-use stall:
  - Stimulus: stall=1 for 2 cycles at pc=8.
  - Required: pc stays 8; id_instruction and id_pc_4 frozen. After release, the W2 fetch resumes.
- Taken branch:
  - Stimulus: id_pc_4=16, branch_imm=16'hFFFC, branch_enable=1.
  - Required: pc <= 0.
  - Flush build: next id_valid=0, id_instruction=0.
  - IF_DELAY_SLOT_EN build: next id_instruction is the word at the old pc, with id_valid=1.
- Branch during stall:
  - Stimulus: stall_beq=1 and branch_enable=1 together for 1 cycle, then branch_enable=1 with stall_beq=0.
  - Required: no redirect in the first cycle; redirect in the second.
- JR and J:
  - Stimulus: is_jr=1, jr_target=32'h0000_0103 with redirect.
  - Required: pc=32'h0000_0100, jr_misalign=1 for exactly 1 cycle.
  - Stimulus: is_jump_index=1, jump_index=26'h0000040, id_pc_4=32'h1000_0008.
  - Required: pc=32'h1000_0100.
- Memory not ready and reset mid-flight:
  - Stimulus: imem_ready=0 for 3 cycles at pc=20.
  - Required: 3 bubbles, pc stays 20.
  - Stimulus: rst=1 asserted together with stall=1 and branch_enable=1.
  - Required: pc=RESET_PC and id_valid=0 on the next edge.
